instr_loader: RTL
=================

Name: instr_loader

Overview:
- Byte-stream program loader that writes the processor's instruction memory at boot or on a reload request.
- Takes a framed byte stream from the serial front end and assembles 16-bit instruction words.
- Drives the memory's write port (write_en, addr, instr_in) one word at a time, holding the CPU off the memory while loading.
- Validates the frame with a length check and an XOR checksum, then reports done or error.

Parameters:
- MAX_WORDS, 191, maximum number of words accepted; equals the instruction memory depth.
- ADDR_BASE, 0, address written for the first payload word.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that arms a new load; ignored unless in IDLE, DONE or ERR.
- rx_valid  input  1  rx_data holds a valid byte.
- rx_data  input  8  received byte.
- rx_ready  output  1  loader accepts the byte this cycle; a byte transfers when rx_valid && rx_ready.
- write_en  output  1  instruction memory write strobe, one cycle per word.
- addr  output  16  instruction memory address.
- instr_in  output  16  word to write.
- cpu_hold  output  1  high from accepted start until DONE or ERR; the processor stalls fetch while it is high.
- load_done  output  1  level; frame loaded and checksum good.
- load_err  output  1  level; length or checksum failure.
- word_count  output  16  words written in the current or last load.

Behaviour:
- Frame format, in byte order: LEN_HI, LEN_LO, then N words sent high byte first, then CHK.
  - N = {LEN_HI, LEN_LO}.
  - CHK makes the XOR of every frame byte, including CHK itself, equal 8'h00.
- Reset values: rx_ready=0, write_en=0, addr=ADDR_BASE, instr_in=0, cpu_hold=0, load_done=0, load_err=0, word_count=0, state=IDLE, running xor=0.
- States:
  - IDLE: rx_ready=0. On start -> S_LEN_HI; set cpu_hold=1; clear done, err, word_count and xor; set addr=ADDR_BASE.
  - S_LEN_HI: rx_ready=1. On transfer, latch len[15:8] -> S_LEN_LO.
  - S_LEN_LO: rx_ready=1. On transfer, latch len[7:0], then:
    - if len > MAX_WORDS -> ERR;
    - else if len == 0 -> S_CHK;
    - else -> S_DATA_HI.
  - S_DATA_HI: rx_ready=1. On transfer, latch the high byte -> S_DATA_LO.
  - S_DATA_LO: rx_ready=1. On transfer, set instr_in={hi, byte} -> S_WRITE.
  - S_WRITE: rx_ready=0, write_en=1 for exactly this one cycle, addr = current address. Then increment addr and word_count.
    - If word_count (after increment) == len -> S_CHK.
    - Else -> S_DATA_HI.
  - S_CHK: rx_ready=1. On transfer:
    - if (xor ^ byte) == 0 -> DONE;
    - else -> ERR.
  - DONE: load_done=1, cpu_hold=0, rx_ready=0. Held until start or rst.
  - ERR: load_err=1, cpu_hold=0, rx_ready=0. Held until start or rst.
- Running xor updates on every accepted byte, including the length bytes.
- Latency: write_en asserts in the cycle after the low byte transfers. Minimum 3 cycles per word; data throughput is one byte per cycle except one bubble per word.
- write_en is never high outside S_WRITE.
  - addr and instr_in are stable for the whole write cycle and hold their values after it.
  - addr does not wrap: since len <= MAX_WORDS, it never exceeds ADDR_BASE+MAX_WORDS-1.
- rx_valid while rx_ready=0 is not consumed; the source must hold the byte.
- start while in a receive or write state is ignored; no restart mid-frame.
- rst mid-frame returns everything to reset values within one cycle.
  - Words already written stay in memory; memory contents are undefined as a program until a good load completes.
- Simultaneous start and rx_valid in IDLE: start is taken; the byte is not consumed that cycle (rx_ready=0 in IDLE).
- Errors stop further writes immediately. A checksum error leaves the words already written in memory; software must reload.

Decomposition:
- Shared package loader_pkg holds:
  - the state encoding (4-bit localparams S_IDLE..S_ERR);
  - FRAME_HDR_BYTES=2;
  - the checksum identity value 8'h00.
- One sub-module is natural: loader_xor_acc (8-bit running XOR with clear and enable). All other logic stays in instr_loader.

Test Plan:
- Good 2-word load: start, then bytes 00 02 00 21 01 01 CHK=23 -> two write_en pulses: addr0=16'h0021, addr1=16'h0101. Then load_done=1, word_count=2, cpu_hold falls.
- Checksum error: same frame with CHK=24 -> both writes occur, then load_err=1, load_done=0.
- Oversize length: bytes 00 C0 (192 > 191) -> load_err=1 after LEN_LO, no write_en ever, rx_ready=0.
- Zero length: 00 00 00 -> load_done=1 with no writes, word_count=0.
- Backpressure and gaps: rx_valid toggles 1-0-1 between bytes, and is held high during S_WRITE -> identical writes and no duplicated bytes.
- Reset mid-frame: assert rst after the 3rd payload byte -> all outputs at reset values next cycle. A following start with a good 1-word frame (00 01 00 2A, CHK=2B) writes 16'h002A at addr0 and sets load_done.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared definitions for the instruction loader: state encoding, frame
// header size and the checksum identity value.
package loader_pkg;

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_LEN_HI  = 4'd1;
    localparam logic [3:0] S_LEN_LO  = 4'd2;
    localparam logic [3:0] S_DATA_HI = 4'd3;
    localparam logic [3:0] S_DATA_LO = 4'd4;
    localparam logic [3:0] S_WRITE   = 4'd5;
    localparam logic [3:0] S_CHK     = 4'd6;
    localparam logic [3:0] S_DONE    = 4'd7;
    localparam logic [3:0] S_ERR     = 4'd8;

    typedef enum logic [3:0] {
        ST_IDLE    = S_IDLE,
        ST_LEN_HI  = S_LEN_HI,
        ST_LEN_LO  = S_LEN_LO,
        ST_DATA_HI = S_DATA_HI,
        ST_DATA_LO = S_DATA_LO,
        ST_WRITE   = S_WRITE,
        ST_CHK     = S_CHK,
        ST_DONE    = S_DONE,
        ST_ERR     = S_ERR
    } state_t;

    localparam int         FRAME_HDR_BYTES = 2;
    localparam logic [7:0] CHK_IDENTITY    = 8'h00;

    // True when folding the final byte into the running XOR yields the identity.
    function automatic logic chk_ok(input logic [7:0] acc, input logic [7:0] b);
        return (acc ^ b) == CHK_IDENTITY;
    endfunction

endpackage

// File: rtl/loader_xor_acc.sv
// 8-bit running XOR accumulator; clear has priority over enable.
module loader_xor_acc (
    input  logic       i_clk,
    input  logic       i_clr,
    input  logic       i_en,
    input  logic [7:0] i_byte,
    output logic [7:0] o_acc
);

    logic [7:0] r_acc;

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_acc <= 8'h00;
        end else if (i_en) begin
            r_acc <= r_acc ^ i_byte;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/instr_loader.sv
// Framed byte-stream program loader: assembles 16-bit words, writes them to
// instruction memory and validates the frame by length and XOR checksum.
module instr_loader
    import loader_pkg::*;
#(
    parameter int          MAX_WORDS = 191,
    parameter logic [15:0] ADDR_BASE = 16'h0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_rx_valid,
    input  logic [7:0]  i_rx_data,
    output logic        o_rx_ready,
    output logic        o_write_en,
    output logic [15:0] o_addr,
    output logic [15:0] o_instr_in,
    output logic        o_cpu_hold,
    output logic        o_load_done,
    output logic        o_load_err,
    output logic [15:0] o_word_count,
    output logic [3:0]  o_state
);

    localparam logic [15:0] LP_MAX_WORDS = MAX_WORDS[15:0];

    // rx handshake: a byte moves on a cycle where i_rx_valid && o_rx_ready.
    // rx_ready is registered and is only high in LEN_HI/LEN_LO/DATA_HI/DATA_LO/CHK.
    state_t      r_state;
    logic [15:0] r_len;
    logic [7:0]  r_hi;
    logic        r_rx_ready;
    logic        r_write_en;
    logic [15:0] r_addr;
    logic [15:0] r_instr;
    logic        r_cpu_hold;
    logic        r_done;
    logic        r_err;
    logic [15:0] r_wcount;

    logic        w_xfer;
    logic        w_can_start;
    logic        w_arm;
    logic        w_xor_clr;
    logic [7:0]  w_xor;
    logic [15:0] w_len_full;
    logic [15:0] w_wcount_next;

    assign w_xfer        = i_rx_valid && r_rx_ready;
    assign w_can_start   = (r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERR);
    assign w_arm         = w_can_start && i_start;
    assign w_xor_clr     = i_rst || w_arm;
    assign w_len_full    = {r_len[15:8], i_rx_data};
    assign w_wcount_next = r_wcount + 16'd1;

    loader_xor_acc u_xor (
        .i_clk  (i_clk),
        .i_clr  (w_xor_clr),
        .i_en   (w_xfer),
        .i_byte (i_rx_data),
        .o_acc  (w_xor)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_len      <= 16'h0000;
            r_hi       <= 8'h00;
            r_rx_ready <= 1'b0;
            r_write_en <= 1'b0;
            r_addr     <= ADDR_BASE;
            r_instr    <= 16'h0000;
            r_cpu_hold <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_wcount   <= 16'h0000;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (i_start) begin
                        r_state    <= ST_LEN_HI;
                        r_rx_ready <= 1'b1;
                        r_cpu_hold <= 1'b1;
                        r_done     <= 1'b0;
                        r_err      <= 1'b0;
                        r_wcount   <= 16'h0000;
                        r_addr     <= ADDR_BASE;
                    end
                end
                ST_LEN_HI: begin
                    if (w_xfer) begin
                        r_len[15:8] <= i_rx_data;
                        r_state     <= ST_LEN_LO;
                    end
                end
                ST_LEN_LO: begin
                    if (w_xfer) begin
                        r_len[7:0] <= i_rx_data;
                        if (w_len_full > LP_MAX_WORDS) begin
                            r_state    <= ST_ERR;
                            r_rx_ready <= 1'b0;
                            r_err      <= 1'b1;
                            r_cpu_hold <= 1'b0;
                        end else if (w_len_full == 16'h0000) begin
                            r_state <= ST_CHK;
                        end else begin
                            r_state <= ST_DATA_HI;
                        end
                    end
                end
                ST_DATA_HI: begin
                    if (w_xfer) begin
                        r_hi    <= i_rx_data;
                        r_state <= ST_DATA_LO;
                    end
                end
                ST_DATA_LO: begin
                    if (w_xfer) begin
                        r_instr    <= {r_hi, i_rx_data};
                        r_state    <= ST_WRITE;
                        r_rx_ready <= 1'b0;
                        r_write_en <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    // The one write cycle; addr/instr stay put until the next word.
                    r_write_en <= 1'b0;
                    r_rx_ready <= 1'b1;
                    r_addr     <= r_addr + 16'd1;
                    r_wcount   <= w_wcount_next;
                    if (w_wcount_next == r_len) begin
                        r_state <= ST_CHK;
                    end else begin
                        r_state <= ST_DATA_HI;
                    end
                end
                ST_CHK: begin
                    if (w_xfer) begin
                        r_rx_ready <= 1'b0;
                        r_cpu_hold <= 1'b0;
                        if (chk_ok(w_xor, i_rx_data)) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_ERR;
                            r_err   <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_rx_ready <= 1'b0;
                    r_write_en <= 1'b0;
                    r_cpu_hold <= 1'b0;
                end
            endcase
        end
    end

    assign o_rx_ready   = r_rx_ready;
    assign o_write_en   = r_write_en;
    assign o_addr       = r_addr;
    assign o_instr_in   = r_instr;
    assign o_cpu_hold   = r_cpu_hold;
    assign o_load_done  = r_done;
    assign o_load_err   = r_err;
    assign o_word_count = r_wcount;
    assign o_state      = r_state;

endmodule
